// File: rtl/vga_pkg.sv
// Shared VGA types: timing widths and the screen selector enum.
package vga_pkg;
  localparam int HC_W  = 11;
  localparam int VC_W  = 11;
  localparam int RGB_W = 12;

  typedef enum logic [1:0] {
    MENU   = 2'd0,
    GAME   = 2'd1,
    P1_WON = 2'd2,
    P2_WON = 2'd3
  } screen_t;
endpackage

// File: rtl/vga_if.sv
// One VGA pixel stream: timing counters, syncs, blanks and colour.
interface vga_if;
  import vga_pkg::*;
  logic [VC_W-1:0]  vcount;
  logic [HC_W-1:0]  hcount;
  logic             vsync;
  logic             hsync;
  logic             vblnk;
  logic             hblnk;
  logic [RGB_W-1:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/screen_sequencer.sv
// Game-screen sequencer: latches game events, switches the displayed source
// only on the vblank rising edge, auto-returns from win screens to the menu.
module screen_sequencer
  import vga_pkg::*;
#(
  parameter int HOLD_FRAMES = 300,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       rst,
  vga_if.in          menu_in,
  vga_if.in          game_in,
  vga_if.in          p1_in,
  vga_if.in          p2_in,
  input  logic       start,
  input  logic       p1_win,
  input  logic       p2_win,
  input  logic       restart,
  vga_if.out         seq_out,
  output logic [1:0] screen
);

  screen_t          state, state_nxt;
  screen_t          pend, req;
  logic             pend_v, req_v;
  logic             vblnk_q;
  logic [CNT_W-1:0] cnt;
  logic             fb, is_win, hold_done;

  assign fb        = game_in.vblnk & ~vblnk_q;
  assign is_win    = (state == P1_WON) || (state == P2_WON);
  assign hold_done = (cnt == CNT_W'(HOLD_FRAMES - 1));
  assign screen    = state;

  // Previous vblank, used to find the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= game_in.vblnk;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= MENU;
    else     state <= state_nxt;
  end

  // Next state: only a frame boundary can move the FSM.
  always_comb begin
    state_nxt = state;
    if (fb) begin
      if (pend_v)                 state_nxt = pend;
      else if (is_win && hold_done) state_nxt = MENU;
    end
  end

  // Legal request for the state in force after this cycle; judging against
  // state_nxt keeps an event on the boundary cycle meaningful next frame.
  always_comb begin
    req_v = 1'b0;
    req   = MENU;
    case (state_nxt)
      MENU: if (start) begin req_v = 1'b1; req = GAME; end
      GAME: begin
        if (p1_win)      begin req_v = 1'b1; req = P1_WON; end
        else if (p2_win) begin req_v = 1'b1; req = P2_WON; end
      end
      default: if (restart) begin req_v = 1'b1; req = MENU; end
    endcase
  end

  // Pending latch: first event in a frame wins; cleared and reloaded on fb.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v <= 1'b0;
      pend   <= MENU;
    end else if (fb || !pend_v) begin
      pend_v <= req_v;
      pend   <= req;
    end
  end

  // Win-screen hold counter, counts boundaries; parked at 0 elsewhere.
  always_ff @(posedge clk) begin
    if (rst || !is_win || (fb && (pend_v || hold_done))) cnt <= '0;
    else if (fb)                                         cnt <= cnt + 1'b1;
  end

  // Output register: timing from the game stream, rgb from the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_out.vcount <= '0;
      seq_out.hcount <= '0;
      seq_out.vsync  <= 1'b0;
      seq_out.hsync  <= 1'b0;
      seq_out.vblnk  <= 1'b0;
      seq_out.hblnk  <= 1'b0;
      seq_out.rgb    <= '0;
    end else begin
      seq_out.vcount <= game_in.vcount;
      seq_out.hcount <= game_in.hcount;
      seq_out.vsync  <= game_in.vsync;
      seq_out.hsync  <= game_in.hsync;
      seq_out.vblnk  <= game_in.vblnk;
      seq_out.hblnk  <= game_in.hblnk;
      case (state)
        MENU:    seq_out.rgb <= menu_in.rgb;
        GAME:    seq_out.rgb <= game_in.rgb;
        P1_WON:  seq_out.rgb <= p1_in.rgb;
        default: seq_out.rgb <= p2_in.rgb;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: shrunken VGA timing, directed scenarios then
// random events, every cycle compared against a frame-level reference model.
module tb_screen_sequencer;
  localparam int HOLD  = 3;
  localparam int H_TOT = 16;
  localparam int V_TOT = 12;
  localparam int V_ACT = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, p1_win, p2_win, restart;
  logic [1:0] screen;

  vga_if menu_if();
  vga_if game_if();
  vga_if p1_if();
  vga_if p2_if();
  vga_if out_if();

  screen_sequencer #(.HOLD_FRAMES(HOLD), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .menu_in(menu_if.in), .game_in(game_if.in), .p1_in(p1_if.in), .p2_in(p2_if.in),
    .start(start), .p1_win(p1_win), .p2_win(p2_win), .restart(restart),
    .seq_out(out_if.out), .screen(screen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: displayed screen, pending request, frames shown on win
  int          m_st, m_pd, m_cnt;
  bit          m_pv, m_pvb, m_fb;
  logic [25:0] e_tim;
  logic [11:0] e_rgb;
  int          hc, vc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] src_rgb(int s);
    case (s)
      0:       return menu_if.rgb;
      1:       return game_if.rgb;
      2:       return p1_if.rgb;
      default: return p2_if.rgb;
    endcase
  endfunction

  task automatic drive_timing();
    logic [25:0] t;
    t = {11'(vc), 11'(hc), (vc == 10), (hc == 13 || hc == 14), (vc >= V_ACT), (hc >= 12)};
    {game_if.vcount, game_if.hcount, game_if.vsync, game_if.hsync, game_if.vblnk, game_if.hblnk} = t;
    {menu_if.vcount, menu_if.hcount, menu_if.vsync, menu_if.hsync, menu_if.vblnk, menu_if.hblnk} = t;
    {p1_if.vcount, p1_if.hcount, p1_if.vsync, p1_if.hsync, p1_if.vblnk, p1_if.hblnk} = t;
    {p2_if.vcount, p2_if.hcount, p2_if.vsync, p2_if.hsync, p2_if.vblnk, p2_if.hblnk} = t;
    menu_if.rgb = 12'($urandom);
    game_if.rgb = 12'($urandom);
    p1_if.rgb   = 12'($urandom);
    p2_if.rgb   = 12'($urandom);
  endtask

  // One clock: update the model from pre-edge inputs, check, advance stimulus.
  task automatic tick();
    @(posedge clk);
    m_fb = 1'b0;
    if (rst) begin
      m_st = 0; m_pv = 0; m_pd = 0; m_cnt = 0; m_pvb = 0;
      e_tim = '0; e_rgb = '0;
    end else begin
      m_fb  = game_if.vblnk && !m_pvb;
      e_tim = {game_if.vcount, game_if.hcount, game_if.vsync, game_if.hsync,
               game_if.vblnk, game_if.hblnk};
      e_rgb = src_rgb(m_st);
      if (m_fb) begin
        if (m_pv) begin
          m_st = m_pd; m_pv = 0; m_cnt = 0;
        end else if (m_st >= 2) begin
          m_cnt++;
          if (m_cnt == HOLD) begin m_st = 0; m_cnt = 0; end
        end
      end
      if (!m_pv) begin
        if (m_st == 0 && start)               begin m_pv = 1; m_pd = 1; end
        else if (m_st == 1 && p1_win)         begin m_pv = 1; m_pd = 2; end
        else if (m_st == 1 && p2_win)         begin m_pv = 1; m_pd = 3; end
        else if (m_st >= 2 && restart)        begin m_pv = 1; m_pd = 0; end
      end
      m_pvb = game_if.vblnk;
    end
    #1;
    chk("screen", 32'(screen), 32'(m_st));
    chk("rgb", 32'(out_if.rgb), 32'(e_rgb));
    chk("timing", 32'({out_if.vcount, out_if.hcount, out_if.vsync, out_if.hsync,
                       out_if.vblnk, out_if.hblnk}), 32'(e_tim));
    start = 0; p1_win = 0; p2_win = 0; restart = 0;
    hc++;
    if (hc == H_TOT) begin hc = 0; vc = (vc + 1) % V_TOT; end
    drive_timing();
  endtask

  task automatic wait_fb();
    int n = 0;
    do begin tick(); n++; end while (!m_fb && n < 2 * H_TOT * V_TOT);
    if (!m_fb) chk("fb_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_vc(int v);
    int n = 0;
    while (vc != v && n < 2 * H_TOT * V_TOT) begin tick(); n++; end
    chk("vc_reach", 32'(vc), 32'(v));
  endtask

  initial begin
    rst = 1; start = 0; p1_win = 0; p2_win = 0; restart = 0;
    hc = 0; vc = 0;
    drive_timing();
    tick(); tick();
    chk("rst_screen", 32'(screen), 32'd0);
    chk("rst_rgb", 32'(out_if.rgb), 32'd0);
    rst = 0;

    // idle: menu shown for over a frame
    repeat (H_TOT * V_TOT + 5) tick();
    chk("idle_menu", 32'(screen), 32'd0);

    // start mid-frame -> game after the next boundary
    wait_vc(5);
    start = 1; tick();
    chk("start_pending", 32'(screen), 32'd0);
    wait_fb();
    chk("to_game", 32'(screen), 32'd1);

    // simultaneous wins -> player 1
    wait_vc(3);
    p1_win = 1; p2_win = 1; tick();
    wait_fb();
    chk("both_p1", 32'(screen), 32'd2);

    // early restart after one frame on the win screen
    wait_fb();
    wait_vc(4);
    restart = 1; tick();
    wait_fb();
    chk("restart_menu", 32'(screen), 32'd0);

    // full hold on P2_WON
    wait_vc(2);
    start = 1; tick();
    wait_fb();
    wait_vc(2);
    p2_win = 1; tick();
    wait_fb();
    chk("p2_enter", 32'(screen), 32'd3);
    wait_fb();
    chk("hold1", 32'(screen), 32'd3);
    wait_fb();
    chk("hold2", 32'(screen), 32'd3);
    wait_fb();
    chk("hold_done", 32'(screen), 32'd0);

    // p1_win in menu is illegal
    wait_vc(3);
    p1_win = 1; tick();
    wait_fb();
    wait_fb();
    chk("menu_ignore", 32'(screen), 32'd0);

    // reset mid-frame while in game
    wait_vc(3);
    start = 1; tick();
    wait_fb();
    chk("game_again", 32'(screen), 32'd1);
    wait_vc(4);
    rst = 1; tick();
    chk("midrst_scr", 32'(screen), 32'd0);
    chk("midrst_out", 32'({out_if.vcount, out_if.hcount, out_if.rgb}), 32'd0);
    rst = 0;
    wait_fb();
    chk("post_rst", 32'(screen), 32'd0);

    // random events, occasional reset
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 39) == 0);
      p1_win  = ($urandom_range(0, 59) == 0);
      p2_win  = ($urandom_range(0, 59) == 0);
      restart = ($urandom_range(0, 99) == 0);
      rst     = ($urandom_range(0, 1999) == 0);
      tick();
      rst = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Game-screen sequencer and output mux placed directly downstream of the full-screen draw stages (menu, game, first-player-won, second-player-won). Tracks game state in an FSM, latches game events, switches the displayed source only at frame boundaries to avoid tearing, and holds a win screen for a fixed number of frames before returning to the menu. Output feeds the final VGA output register stage.

## Interface
- `HOLD_FRAMES`, 300: frames a win screen is shown before auto-return to menu (≥1).
- `CNT_W`, 10: width of the frame hold counter; must hold HOLD_FRAMES.
- `clk`  in  1  pixel clock.
- `rst`  in  1  reset, synchronous, active-high.
- `menu_in`  vga_if.in  —  menu screen stream.
- `game_in`  vga_if.in  —  gameplay stream; also the timing reference.
- `p1_in`  vga_if.in  —  first-player-won stream.
- `p2_in`  vga_if.in  —  second-player-won stream.
- `start`  in  1  single-cycle pulse: begin game.
- `p1_win`  in  1  single-cycle pulse: player 1 won.
- `p2_win`  in  1  single-cycle pulse: player 2 won.
- `restart`  in  1  single-cycle pulse: leave win screen early.
- `seq_out`  vga_if.out  —  selected stream.
- `screen`  out  2  current displayed screen (0 MENU, 1 GAME, 2 P1_WON, 3 P2_WON).

## Operation
- All four input streams are timing-aligned; vcount/hcount/syncs/blanks forwarded from `game_in`, rgb from the selected source.
- Frame boundary `fb`: rising edge of `game_in.vblnk` (vblnk high, registered previous vblnk low). One cycle per frame.
- Event latch: a 2-bit pending request register captures events between boundaries; the FSM acts only on `fb`.
  - MENU: `start` → pending GAME.
  - GAME: `p1_win` → pending P1_WON; `p2_win` → pending P2_WON; same-cycle both → P1_WON. First latched event wins; later events in the same frame ignored.
  - P1_WON/P2_WON: `restart` → pending MENU.
  - Events not legal in the current state are dropped.
- FSM states MENU, GAME, P1_WON, P2_WON; on `fb`: if pending valid → go to pending state, clear pending, clear hold counter.
- Hold: in P1_WON/P2_WON, counter increments on each `fb` without a pending request; when counter reaches HOLD_FRAMES−1 at an `fb`, go to MENU, counter cleared. Pending `restart` on the same `fb` has same result.
- Counter saturates logic irrelevant outside win states; held at 0.
- rgb selection uses the state register value, never the pending value.

## Timing
- Reset: state MENU, pending cleared, counter 0, `screen`=0, all `seq_out` fields 0, registered vblnk 0.
- Datapath latency: 1 clk; `seq_out` fields are `game_in` fields / selected rgb registered once.
- State changes take effect on the cycle after `fb`; the new source is visible from the first pixel after that (inside vertical blanking, so no torn frame).
- Event arriving on the same cycle as `fb`: latched for the next boundary, not applied now.
- `screen` updates in the same cycle as the state register.
- Reset asserted mid-frame: next cycle outputs at reset values; resume on next `fb` with state MENU.

## Structure
- Package `vga_pkg` gains `screen_t` enum (MENU=2'd0, GAME=2'd1, P1_WON=2'd2, P2_WON=2'd3).
- HOLD_FRAMES stays a module parameter; top passes 300 (≈5 s at 60 Hz).
- Single module; no sub-module. Event latch, FSM, counter, and output register in separate always blocks.

## Test plan
- Reset then free-running timing, no events → `screen`=0, rgb equals `menu_in.rgb` delayed 1 clk for a full frame.
- `start` mid-frame at vcount 300 → `screen` stays 0 until cycle after next vblnk rise, then 1; rgb follows `game_in`.
- In GAME, `p1_win` and `p2_win` same cycle → after next `fb`, `screen`=2.
- HOLD_FRAMES=3: enter P2_WON → exactly 3 `fb` later `screen`=0.
- In P1_WON, `restart` after 1 frame → `screen`=0 at next `fb`; counter 0.
- `p1_win` while in MENU → ignored, `screen` stays 0 for 2 frames; `rst` mid-frame in GAME → next cycle all outputs 0, `screen`=0.
